temp_seg_display: RTL and testbench

Downstream display stage for the temperature path. Captures an 8-bit unsigned temperature word from the sensor wrapper, converts it to three BCD digits with a sequential shift-add-3 (double-dabble) engine, and time-multiplexes the digits onto the board's common-anode seven-segment display. It drives the display's anode and cathode lines directly. The converter and the scan timebase run independently, so the display never flickers during a conversion.

---
 rtl/temp_seg_display.sv | 154 +++++++++++++++
 tb/tb_temp_seg_display.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/temp_seg_display.sv
// Temperature display stage: double-dabble conversion of an 8-bit word into
// three BCD digits, scanned onto a common-anode seven-segment display.
module temp_seg_display #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] temp_in,
  input  logic       temp_valid,
  output logic       busy,
  output logic [7:0] out_anode,
  output logic [7:0] out_cathode,
  output logic [1:0] debug_state
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, LOAD = 2'd2} state_t;
  typedef enum logic [1:0] {SEL_HUND = 2'd0, SEL_TENS = 2'd1, SEL_ONES = 2'd2} sel_t;

  state_t      state;
  logic [7:0]  bin;
  logic [11:0] bcd;
  logic [2:0]  iter;
  logic [3:0]  hund;
  logic [3:0]  tens;
  logic [3:0]  ones;
  logic [7:0]  bcd_adj;

  logic [CW-1:0] refresh_cnt;
  sel_t          sel;
  logic [3:0]    cur_digit;
  logic          cur_blank;
  logic [7:0]    cur_anode;

  assign debug_state = state;

  // Hundreds never exceeds 1 before a shift for an 8-bit input, so only the
  // tens and ones nibbles can ever need the +3 correction.
  always_comb begin
    bcd_adj = bcd[7:0];
    if (bcd[3:0] >= 4'd5) bcd_adj[3:0] = bcd[3:0] + 4'd3;
    if (bcd[7:4] >= 4'd5) bcd_adj[7:4] = bcd[7:4] + 4'd3;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      bin   <= 8'd0;
      bcd   <= 12'd0;
      iter  <= 3'd0;
      hund  <= 4'd0;
      tens  <= 4'd0;
      ones  <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (temp_valid) begin
            bin   <= temp_in;
            bcd   <= 12'd0;
            iter  <= 3'd0;
            state <= CONV;
            busy  <= 1'b1;
          end
        end
        CONV: begin
          bcd  <= {bcd[10:8], bcd_adj, bin[7]};
          bin  <= {bin[6:0], 1'b0};
          iter <= iter + 3'd1;
          if (iter == 3'd7) state <= LOAD;
        end
        LOAD: begin
          hund  <= bcd[11:8];
          tens  <= bcd[7:4];
          ones  <= bcd[3:0];
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      refresh_cnt <= '0;
      sel         <= SEL_HUND;
    end else if (refresh_cnt == CW'(REFRESH_DIV - 1)) begin
      refresh_cnt <= '0;
      case (sel)
        SEL_HUND: sel <= SEL_TENS;
        SEL_TENS: sel <= SEL_ONES;
        default:  sel <= SEL_HUND;
      endcase
    end else begin
      refresh_cnt <= refresh_cnt + CW'(1);
    end
  end

  function automatic logic [7:0] seg_pattern(input logic [3:0] d);
    case (d)
      4'd0:    seg_pattern = 8'h03;
      4'd1:    seg_pattern = 8'h9F;
      4'd2:    seg_pattern = 8'h25;
      4'd3:    seg_pattern = 8'h0D;
      4'd4:    seg_pattern = 8'h99;
      4'd5:    seg_pattern = 8'h49;
      4'd6:    seg_pattern = 8'h41;
      4'd7:    seg_pattern = 8'h1F;
      4'd8:    seg_pattern = 8'h01;
      4'd9:    seg_pattern = 8'h09;
      default: seg_pattern = 8'hFF;
    endcase
  endfunction

  // Leading-zero blanking: hundreds blank on 0, tens blank only when hundreds is also 0.
  always_comb begin
    cur_digit = ones;
    cur_blank = 1'b0;
    cur_anode = 8'hDF;
    case (sel)
      SEL_HUND: begin
        cur_digit = hund;
        cur_blank = (hund == 4'd0);
        cur_anode = 8'h7F;
      end
      SEL_TENS: begin
        cur_digit = tens;
        cur_blank = (hund == 4'd0) && (tens == 4'd0);
        cur_anode = 8'hBF;
      end
      default: begin
        cur_digit = ones;
        cur_blank = 1'b0;
        cur_anode = 8'hDF;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_anode   <= 8'hFF;
      out_cathode <= 8'hFF;
    end else begin
      out_anode   <= cur_anode;
      out_cathode <= cur_blank ? 8'hFF : seg_pattern(cur_digit);
    end
  end

endmodule

// File: tb/tb_temp_seg_display.sv
// Directed bench for temp_seg_display: table of conversions checked against
// hand-computed digit patterns, plus overlap and reset corner sequences.
module tb_temp_seg_display;

  localparam int DIV = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] temp_in = 8'd0;
  logic       temp_valid = 1'b0;
  logic       busy;
  logic [7:0] out_anode;
  logic [7:0] out_cathode;
  logic [1:0] debug_state;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  temp_seg_display #(.REFRESH_DIV(DIV)) dut (
    .clock(clock),
    .reset(reset),
    .temp_in(temp_in),
    .temp_valid(temp_valid),
    .busy(busy),
    .out_anode(out_anode),
    .out_cathode(out_cathode),
    .debug_state(debug_state)
  );

  always #5 clock = ~clock;

  // Cycles since reset released; cycle 0 is the first cycle with reset low.
  always @(posedge clock) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  typedef struct {
    logic [7:0] temp;
    logic [7:0] cath_h;
    logic [7:0] cath_t;
    logic [7:0] cath_o;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic check_frame(input logic [7:0] ch, input logic [7:0] ct,
                             input logic [7:0] co, input int ncyc);
    logic [7:0] ea;
    logic [7:0] ec;
    int slot;
    repeat (ncyc) begin
      @(negedge clock);
      if (cyc == 0) begin
        ea = 8'hFF;
        ec = 8'hFF;
      end else begin
        slot = ((cyc - 1) / DIV) % 3;
        ea = (slot == 0) ? 8'h7F : (slot == 1) ? 8'hBF : 8'hDF;
        ec = (slot == 0) ? ch : (slot == 1) ? ct : co;
      end
      check("anode", out_anode, ea);
      check("cathode", out_cathode, ec);
    end
  endtask

  // Pulse temp_valid in cycle N, then check busy for N..N+10, optionally
  // offering a second sample at N+3; ends in cycle N+11.
  task automatic convert(input logic [7:0] v, input logic inject, input logic [7:0] v2);
    @(posedge clock); #1;
    temp_in = v;
    temp_valid = 1'b1;
    @(negedge clock);
    check("busy_n", {7'd0, busy}, 8'd0);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clock); #1;
      temp_valid = inject && (k == 3);
      if (inject && k == 3) temp_in = v2;
      @(negedge clock);
      check("busy", {7'd0, busy}, (k <= 9) ? 8'd1 : 8'd0);
    end
    @(posedge clock); #1;
    temp_valid = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'd25,  8'hFF, 8'h25, 8'h49};
    vecs[1] = '{8'd255, 8'h25, 8'h49, 8'h49};
    vecs[2] = '{8'd7,   8'hFF, 8'hFF, 8'h1F};
    vecs[3] = '{8'd100, 8'h9F, 8'h03, 8'h03};
    vecs[4] = '{8'd0,   8'hFF, 8'hFF, 8'h03};
    vecs[5] = '{8'd50,  8'hFF, 8'h49, 8'h03};
    vecs[6] = '{8'd109, 8'h9F, 8'h03, 8'h09};

    // Reset and idle scan of a zero display
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    check_frame(8'hFF, 8'hFF, 8'h03, 1 + 3 * DIV);
    check("busy_idle", {7'd0, busy}, 8'd0);

    foreach (vecs[i]) begin
      convert(vecs[i].temp, 1'b0, 8'd0);
      check_frame(vecs[i].cath_h, vecs[i].cath_t, vecs[i].cath_o, 3 * DIV + 1);
    end

    // Second sample during conversion is dropped
    convert(8'd100, 1'b1, 8'd42);
    check_frame(8'h9F, 8'h03, 8'h03, 2 * 3 * DIV);
    check("busy_after_drop", {7'd0, busy}, 8'd0);

    // Reset mid-conversion discards the in-flight value
    convert(8'd7, 1'b0, 8'd0);
    @(posedge clock); #1;
    temp_in = 8'd200;
    temp_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clock); #1;
      temp_valid = 1'b0;
      @(negedge clock);
      check("busy_pre_rst", {7'd0, busy}, 8'd1);
    end
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    check("busy_rst_cycle", {7'd0, busy}, 8'd1);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("busy_post_rst", {7'd0, busy}, 8'd0);
    check("anode_post_rst", out_anode, 8'hFF);
    check("cathode_post_rst", out_cathode, 8'hFF);
    check_frame(8'hFF, 8'hFF, 8'h03, 3 * 3 * DIV);

    // Reset and temp_valid together: reset wins
    convert(8'd255, 1'b0, 8'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    temp_valid = 1'b1;
    temp_in = 8'd99;
    @(posedge clock); #1;
    reset = 1'b0;
    temp_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check("busy_simul", {7'd0, busy}, 8'd0);
    end
    check_frame(8'hFF, 8'hFF, 8'h03, 2 * 3 * DIV);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
